polaris_bus_arbiter: RTL
========================

POLARIS_BUS_ARBITER -- requirements
Module: polaris_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of grant cycles without mack_i before forced termination; 0 disables the timeout.
REQ-002 SHALL have port clk_i  in  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i  in  1: reset, asynchronous, active-low.
REQ-004 SHALL have I-side ports iadr_i in 64 (fetch address), isiz_i in 2 (fetch request when nonzero), iack_o out 1 (fetch done), idat_o out 32 (instruction word).
REQ-005 SHALL have D-side inputs: dadr_i 64, ddat_i 64 (write data), dwe_i 1, dcyc_i 1, dstb_i 1, dsiz_i 2, dsigned_i 1.
REQ-006 SHALL have D-side outputs: ddat_o 64 (read data) and dack_o 1 (done).
REQ-007 SHALL have memory-side outputs: madr_o 64, mdat_o 64, mwe_o 1, mcyc_o 1, mstb_o 1, msiz_o 2, msigned_o 1.
REQ-008 SHALL have memory-side inputs mdat_i in 64 and mack_i in 1.
REQ-009 SHALL have port berr_o  out  1: one-cycle pulse on a timeout.

Function
REQ-010 SHALL implement states IDLE, IGNT, DGNT, RESP; all outputs registered.
REQ-011 IDLE: a D request (dcyc_i & dstb_i) SHALL go to DGNT; otherwise an I request (isiz_i != 0) SHALL go to IGNT; otherwise stay in IDLE.
REQ-012 D requests SHALL win when D and I requests coincide in IDLE.
REQ-013 On the IDLE->grant edge, the block SHALL latch the winner's address, size and write data and present them on the m* outputs in the following cycle, with mcyc_o=mstb_o=1.
REQ-014 In IGNT, the m* outputs SHALL be: madr_o=iadr_i, msiz_o=isiz_i, mwe_o=0, msigned_o=0, mdat_o=0.
REQ-015 In DGNT, dadr_i, ddat_i, dwe_i, dsiz_i and dsigned_i SHALL pass unchanged to madr_o, mdat_o, mwe_o, msiz_o and msigned_o.
REQ-016 Requester inputs SHALL be ignored outside IDLE; latched values SHALL hold for the whole grant.
REQ-017 On mack_i in a grant state, the block SHALL deassert mcyc_o/mstb_o and capture mdat_i on the next edge, then enter RESP.
REQ-018 RESP SHALL last one cycle: iack_o=1 (after IGNT) or dack_o=1 (after DGNT), then return to IDLE.
REQ-019 Fetch latency SHALL be: request seen in IDLE -> iack_o 3 cycles later when memory acks in the first grant cycle; each memory wait state adds one cycle.
REQ-020 idat_o SHALL be the captured mdat_i[63:32] when the latched iadr bit 2 = 1, else mdat_i[31:0].
REQ-021 ddat_o SHALL be the captured mdat_i; sign and zero extension are the memory's job.
REQ-022 idat_o and ddat_o SHALL hold their values until the next RESP; they are valid only while the matching ack is high.
REQ-023 SHALL count grant cycles; when the count reaches TIMEOUT without mack_i (TIMEOUT != 0), the block SHALL end the cycle as in REQ-017.
REQ-024 On a timeout, captured data SHALL be all-ones (idat_o=32'hFFFF_FFFF, ddat_o=64'hFFFF_FFFF_FFFF_FFFF) and berr_o SHALL pulse in RESP.
REQ-025 mack_i SHALL win over timeout expiry in the same cycle.
REQ-026 mack_i SHALL be ignored in IDLE and RESP.
REQ-027 A request still asserted in the RESP cycle SHALL NOT be taken; it is resampled in IDLE on the next cycle.
REQ-028 iack_o and dack_o SHALL never be high together, and SHALL never be high outside RESP.

Reset
REQ-029 reset_i low SHALL force IDLE at once, without a clock.
REQ-030 Reset SHALL clear to 0: all m* outputs, iack_o, dack_o, berr_o, idat_o, ddat_o and the timeout counter.
REQ-031 Reset during a grant SHALL drop mcyc_o/mstb_o immediately and SHALL NOT produce an ack after reset is released.
REQ-032 The first request SHALL be accepted on the first rising edge with reset_i high.

Verification
REQ-033 Fetch: iadr_i=0x...FF04, isiz_i=2, mack_i in the first grant cycle, mdat_i=0x11111111_22222222 -> madr_o=0x...FF04, msiz_o=2; iack_o pulses 3 cycles after the request with idat_o=0x11111111.
REQ-034 Collision: I and D request in the same IDLE cycle, dadr_i=0x100, dwe_i=1, ddat_i=0xAB -> D served first (mwe_o=1, mdat_o=0xAB, dack_o); the I fetch is then granted without iack_o being lost.
REQ-035 Wait states: D read, dsiz_i=3, dsigned_i=1, mack_i after 5 cycles -> mcyc_o held for exactly 5 cycles, msigned_o=1, dack_o with ddat_o=mdat_i, berr_o stays 0.
REQ-036 Timeout: TIMEOUT=4, mack_i never asserted -> mcyc_o drops after 4 grant cycles; dack_o and berr_o pulse together with ddat_o all-ones.
REQ-037 Reset mid-grant: reset_i low while mcyc_o=1 -> mcyc_o=0 with no clock edge; no ack follows; the next request completes normally.

Source files
------------

// File: rtl/polaris_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : polaris_bus_arbiter
// Purpose  : Two-master (instruction fetch / data) to single memory port
//            arbiter. Data requests win ties. The winner's request is latched
//            for the whole grant. A memory ack or a grant timeout ends the
//            cycle. A one-cycle response state then returns the captured data
//            with iack_o or dack_o.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, reset_i        : clock, asynchronous active-low reset
//   iadr_i, isiz_i        : fetch address / size (request when size != 0)
//   iack_o, idat_o        : fetch done, selected 32-bit instruction word
//   dadr_i .. dsigned_i   : data-side request (dcyc_i & dstb_i requests)
//   ddat_o, dack_o        : data-side read data, done
//   madr_o .. msigned_o   : memory-side request outputs
//   mdat_i, mack_i        : memory read data and acknowledge
//   berr_o                : one-cycle pulse with the ack of a timed-out cycle
// ============================================================================
module polaris_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // instruction side
  input  logic [63:0] iadr_i,
  input  logic [1:0]  isiz_i,
  output logic        iack_o,
  output logic [31:0] idat_o,
  // data side
  input  logic [63:0] dadr_i,
  input  logic [63:0] ddat_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  output logic [63:0] ddat_o,
  output logic        dack_o,
  // memory side
  output logic [63:0] madr_o,
  output logic [63:0] mdat_o,
  output logic        mwe_o,
  output logic        mcyc_o,
  output logic        mstb_o,
  output logic [1:0]  msiz_o,
  output logic        msigned_o,
  input  logic [63:0] mdat_i,
  input  logic        mack_i,
  // error
  output logic        berr_o
);

  // The counter only needs to reach TIMEOUT-1 (the last grant cycle index).
  localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IGNT = 2'd1,
    S_DGNT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [63:0]         r_madr;
  logic [63:0]         r_mdat;
  logic                r_mwe;
  logic                r_mcyc;
  logic                r_mstb;
  logic [1:0]          r_msiz;
  logic                r_msigned;
  logic                r_isel;     // latched fetch address bit 2
  logic [c_CNT_W-1:0]  r_cnt;
  logic [63:0]         r_cap;      // memory data captured when the cycle ends
  logic                r_tmo;      // cycle was ended by the timeout
  logic                r_iack;
  logic                r_dack;
  logic                r_berr;
  logic [31:0]         r_idat;
  logic [63:0]         r_ddat;

  logic                w_dreq;
  logic                w_ireq;
  logic                w_grant;
  logic                w_mack;
  logic                w_expire;
  logic                w_end;

  assign w_dreq   = dcyc_i & dstb_i;
  assign w_ireq   = |isiz_i;
  assign w_grant  = (r_state == S_IGNT) || (r_state == S_DGNT);
  // mack_i only counts while the bus cycle is still open in a grant state.
  assign w_mack   = w_grant & r_mcyc & mack_i;
  // An ack in the same cycle as expiry takes precedence.
  assign w_expire = (TIMEOUT != 0) && w_grant && r_mcyc && !mack_i && (r_cnt == c_CNT_LAST);
  assign w_end    = w_mack | w_expire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state. A grant state is left one cycle after the bus cycle closes,
  // so the closing edge and the response edge are distinct.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dreq) begin
          w_next = S_DGNT;
        end else if (w_ireq) begin
          w_next = S_IGNT;
        end
      end
      S_IGNT, S_DGNT: begin
        if (!r_mcyc) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_madr    <= '0;
      r_mdat    <= '0;
      r_mwe     <= 1'b0;
      r_mcyc    <= 1'b0;
      r_mstb    <= 1'b0;
      r_msiz    <= '0;
      r_msigned <= 1'b0;
      r_isel    <= 1'b0;
      r_cnt     <= '0;
      r_cap     <= '0;
      r_tmo     <= 1'b0;
      r_iack    <= 1'b0;
      r_dack    <= 1'b0;
      r_berr    <= 1'b0;
      r_idat    <= '0;
      r_ddat    <= '0;
    end else begin
      // Response strobes are single-cycle by default.
      r_iack <= 1'b0;
      r_dack <= 1'b0;
      r_berr <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_dreq) begin
            r_madr    <= dadr_i;
            r_mdat    <= ddat_i;
            r_mwe     <= dwe_i;
            r_msiz    <= dsiz_i;
            r_msigned <= dsigned_i;
            r_mcyc    <= 1'b1;
            r_mstb    <= 1'b1;
          end else if (w_ireq) begin
            r_madr    <= iadr_i;
            r_mdat    <= '0;
            r_mwe     <= 1'b0;
            r_msiz    <= isiz_i;
            r_msigned <= 1'b0;
            r_isel    <= iadr_i[2];
            r_mcyc    <= 1'b1;
            r_mstb    <= 1'b1;
          end
        end

        S_IGNT, S_DGNT: begin
          if (r_mcyc) begin
            if (w_end) begin
              r_mcyc <= 1'b0;
              r_mstb <= 1'b0;
              r_cap  <= w_mack ? mdat_i : '1;
              r_tmo  <= ~w_mack;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end else begin
            // Bus cycle already closed: this edge enters the response state.
            r_berr <= r_tmo;
            if (r_state == S_IGNT) begin
              r_iack <= 1'b1;
              r_idat <= r_isel ? r_cap[63:32] : r_cap[31:0];
            end else begin
              r_dack <= 1'b1;
              r_ddat <= r_cap;
            end
          end
        end

        default: begin
          // S_RESP: strobes fall via the defaults above.
        end
      endcase
    end
  end

  assign madr_o    = r_madr;
  assign mdat_o    = r_mdat;
  assign mwe_o     = r_mwe;
  assign mcyc_o    = r_mcyc;
  assign mstb_o    = r_mstb;
  assign msiz_o    = r_msiz;
  assign msigned_o = r_msigned;
  assign iack_o    = r_iack;
  assign idat_o    = r_idat;
  assign dack_o    = r_dack;
  assign ddat_o    = r_ddat;
  assign berr_o    = r_berr;

endmodule
`default_nettype wire
